// File: rtl/seq_radix4_multiplier.sv
// Sequential radix-4 shift-add multiplier: two multiplier bits per cycle, signed/unsigned
// operands, optional early exit on leading-zero pairs, valid/ready on both sides.
module seq_radix4_multiplier #(
  parameter int unsigned A_W        = 16,
  parameter int unsigned B_W        = 16,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               is_signed,
  input  logic               vld,
  output logic               rdy,
  output logic [A_W+B_W-1:0] c,
  output logic               result_vld,
  input  logic               result_rdy,
  output logic               busy
);

  localparam int unsigned P_W   = A_W + B_W;
  localparam int unsigned Pairs = B_W / 2;
  localparam int unsigned CntW  = (Pairs > 1) ? $clog2(Pairs) : 1;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e          state_q, state_d;
  logic [P_W-1:0]  mag_a_sh_q, mag_a_sh_d;
  logic [B_W-1:0]  mag_b_rem_q, mag_b_rem_d;
  logic            neg_q, neg_d;
  logic [P_W-1:0]  acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]  c_q, c_d;

  logic [A_W-1:0]  a_mag;
  logic [B_W-1:0]  b_mag;
  logic [P_W-1:0]  pp;
  logic [P_W-1:0]  acc_sum;
  logic            last_pair;

  // The most-negative operand negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    a_mag = (is_signed && a[A_W-1]) ? (~a + A_W'(1)) : a;
    b_mag = (is_signed && b[B_W-1]) ? (~b + B_W'(1)) : b;
  end

  // x0..x3 partial product from the low multiplier pair, built from shift and add.
  always_comb begin
    pp = '0;
    if (mag_b_rem_q[0]) pp = mag_a_sh_q;
    if (mag_b_rem_q[1]) pp = pp + (mag_a_sh_q << 1);
    acc_sum   = acc_q + pp;
    last_pair = (cnt_q == CntW'(Pairs - 1)) ||
                (EARLY_EXIT && ((mag_b_rem_q >> 2) == '0));
  end

  always_comb begin
    state_d     = state_q;
    mag_a_sh_d  = mag_a_sh_q;
    mag_b_rem_d = mag_b_rem_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    unique case (state_q)
      StIdle: begin
        if (vld) begin
          mag_a_sh_d  = P_W'(a_mag);
          mag_b_rem_d = b_mag;
          neg_d       = is_signed & (a[A_W-1] ^ b[B_W-1]);
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = StMul;
        end
      end
      StMul: begin
        acc_d       = acc_sum;
        mag_a_sh_d  = mag_a_sh_q << 2;
        mag_b_rem_d = mag_b_rem_q >> 2;
        cnt_d       = cnt_q + 1'b1;
        if (last_pair) begin
          c_d     = neg_q ? (~acc_sum + P_W'(1)) : acc_sum;
          state_d = StDone;
        end
      end
      StDone: begin
        if (result_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mag_a_sh_q  <= '0;
      mag_b_rem_q <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      c_q         <= '0;
    end else begin
      state_q     <= state_d;
      mag_a_sh_q  <= mag_a_sh_d;
      mag_b_rem_q <= mag_b_rem_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
    end
  end

  assign rdy        = (state_q == StIdle);
  assign result_vld = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign c          = c_q;

endmodule

// File: tb/tb_seq_radix4_multiplier.sv
// Bench for seq_radix4_multiplier: two instances (early exit on / off) driven independently,
// checked against an arithmetic product and bit-pair latency model.
module tb_seq_radix4_multiplier;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_s [2];
  logic [15:0] b_s [2];
  logic [1:0]  sgn_s;
  logic [1:0]  vld_s;
  logic [1:0]  rres_s;
  logic [1:0]  rdy_w;
  logic [1:0]  rvld_w;
  logic [1:0]  busy_w;
  logic [31:0] c_w [2];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: fixed latency, index 1: early exit.
  seq_radix4_multiplier #(.A_W(16), .B_W(16), .EARLY_EXIT(1'b0)) u_dut_fix (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a_s[0]),
    .b          (b_s[0]),
    .is_signed  (sgn_s[0]),
    .vld        (vld_s[0]),
    .rdy        (rdy_w[0]),
    .c          (c_w[0]),
    .result_vld (rvld_w[0]),
    .result_rdy (rres_s[0]),
    .busy       (busy_w[0])
  );

  seq_radix4_multiplier #(.A_W(16), .B_W(16), .EARLY_EXIT(1'b1)) u_dut_ee (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a_s[1]),
    .b          (b_s[1]),
    .is_signed  (sgn_s[1]),
    .vld        (vld_s[1]),
    .rdy        (rdy_w[1]),
    .c          (c_w[1]),
    .result_vld (rvld_w[1]),
    .result_rdy (rres_s[1]),
    .busy       (busy_w[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: true product of the interpreted operands, latency from significant bit pairs.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic sgn,
                                input bit ee, output logic [31:0] pc, output int n);
    longint sa, sb, p, mbabs;
    int nb;
    sa = sgn ? longint'($signed(ma)) : longint'(ma);
    sb = sgn ? longint'($signed(mb)) : longint'(mb);
    p  = sa * sb;
    pc = p[31:0];
    mbabs = (sb < 0) ? -sb : sb;
    nb = 0;
    while ((mbabs >> nb) != 0) nb++;
    if (ee) n = ((nb + 1) / 2 < 1) ? 1 : (nb + 1) / 2;
    else n = 8;
  endfunction

  task automatic run_txn(input int sel, input logic [15:0] ta, input logic [15:0] tb,
                         input logic sgn, input int stall, input logic [31:0] exp_c,
                         input int exp_n, input string tag);
    int lat;
    bit done;
    @(negedge clk);
    for (int i = 0; i < 50 && !rdy_w[sel]; i++) @(negedge clk);
    check({tag, ":rdy_before"}, 64'(rdy_w[sel]), 64'd1);
    a_s[sel] = ta; b_s[sel] = tb; sgn_s[sel] = sgn; vld_s[sel] = 1'b1; rres_s[sel] = 1'b0;
    @(posedge clk); #1;
    vld_s[sel] = 1'b0;
    lat = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (rvld_w[sel]) done = 1'b1;
    end
    check({tag, ":latency"}, 64'(lat), 64'(exp_n));
    check({tag, ":c"}, 64'(c_w[sel]), 64'(exp_c));
    repeat (stall) begin
      @(posedge clk); #1;
    end
    if (stall > 0) begin
      check({tag, ":hold_vld"}, 64'(rvld_w[sel]), 64'd1);
      check({tag, ":hold_c"}, 64'(c_w[sel]), 64'(exp_c));
    end
    @(negedge clk);
    rres_s[sel] = 1'b1;
    @(posedge clk); #1;
    rres_s[sel] = 1'b0;
    check({tag, ":post_vld"}, 64'(rvld_w[sel]), 64'd0);
    check({tag, ":post_rdy"}, 64'(rdy_w[sel]), 64'd1);
  endtask

  task automatic rand_loop(input int sel, input int count);
    logic [15:0] ra, rb;
    logic rs;
    logic [31:0] pc;
    int n, st;
    for (int i = 0; i < count; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rb = rb >> $urandom_range(0, 16);
      rs = 1'($urandom);
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      model(ra, rb, rs, sel == 1, pc, n);
      run_txn(sel, ra, rb, rs, st, pc, n, sel == 1 ? "rand_ee" : "rand_fix");
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    for (int s = 0; s < 2; s++) begin
      a_s[s] = '0; b_s[s] = '0;
    end
    sgn_s = '0; vld_s = '0; rres_s = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", 64'(rdy_w), 64'b11);
    check("reset_vld", 64'(rvld_w), 64'b00);
    check("reset_busy", 64'(busy_w), 64'b00);
    check("reset_c", 64'(c_w[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(1, 16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE0001, 8, "umax_ee");
    run_txn(0, 16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE0001, 8, "umax_fix");
    run_txn(1, 16'h1234, 16'h0003, 1'b0, 0, 32'h0000369C, 1, "b3_ee");
    run_txn(1, 16'h1234, 16'h0000, 1'b0, 0, 32'h00000000, 1, "b0_ee");
    run_txn(1, 16'h1234, 16'h0100, 1'b0, 0, 32'h00123400, 5, "b100_ee");
    run_txn(0, 16'h1234, 16'h0003, 1'b0, 0, 32'h0000369C, 8, "b3_fix");
    run_txn(0, 16'h1234, 16'h0000, 1'b0, 0, 32'h00000000, 8, "b0_fix");
    run_txn(0, 16'h1234, 16'h0100, 1'b0, 0, 32'h00123400, 8, "b100_fix");
    run_txn(1, 16'h8000, 16'hFFFF, 1'b1, 0, 32'h00008000, 1, "smin_ee");
    run_txn(1, 16'hFFFD, 16'h0005, 1'b1, 0, 32'hFFFFFFF1, 2, "sneg_ee");
    run_txn(1, 16'hFFFD, 16'h0005, 1'b0, 0, 32'h0004FFF1, 2, "uneg_ee");
    run_txn(0, 16'h8000, 16'h8000, 1'b1, 2, 32'h40000000, 8, "sminsq_fix");

    // Back-pressure with a competing request held on vld.
    @(negedge clk);
    a_s[1] = 16'd3; b_s[1] = 16'd5; sgn_s[1] = 1'b0; vld_s[1] = 1'b1; rres_s[1] = 1'b0;
    @(posedge clk); #1;
    a_s[1] = 16'd9; b_s[1] = 16'd9;
    lat = 0;
    while (!rvld_w[1] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp:latency", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp:hold_vld", 64'(rvld_w[1]), 64'd1);
      check("bp:hold_c", 64'(c_w[1]), 64'd15);
      check("bp:hold_rdy", 64'(rdy_w[1]), 64'd0);
    end
    @(negedge clk);
    rres_s[1] = 1'b1;
    @(posedge clk); #1;
    rres_s[1] = 1'b0;
    check("bp:idle_rdy", 64'(rdy_w[1]), 64'd1);
    check("bp:idle_vld", 64'(rvld_w[1]), 64'd0);
    @(posedge clk); #1;
    vld_s[1] = 1'b0;
    check("bp:accepted", 64'({busy_w[1], rdy_w[1]}), 64'b10);
    lat = 0;
    while (!rvld_w[1] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp2:latency", 64'(lat), 64'd2);
    check("bp2:c", 64'(c_w[1]), 64'd81);
    @(negedge clk);
    rres_s[1] = 1'b1;
    @(posedge clk); #1;
    rres_s[1] = 1'b0;

    // Asynchronous reset in the third MUL cycle.
    @(negedge clk);
    a_s[1] = 16'hFFFF; b_s[1] = 16'hFFFF; sgn_s[1] = 1'b0; vld_s[1] = 1'b1;
    @(posedge clk); #1;
    vld_s[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid:rdy", 64'(rdy_w[1]), 64'd1);
    check("rst_mid:vld", 64'(rvld_w[1]), 64'd0);
    check("rst_mid:busy", 64'(busy_w[1]), 64'd0);
    check("rst_mid:c", 64'(c_w[1]), 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rvld_w[1]) seen = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (rvld_w[1]) seen = 1'b1;
    end
    check("rst_mid:no_pulse", 64'(seen), 64'd0);
    run_txn(1, 16'd7, 16'd6, 1'b0, 0, 32'd42, 2, "after_rst");

    fork
      rand_loop(1, 5000);
      rand_loop(0, 5000);
    join

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
